// File: rtl/pc_fetch_sequencer.sv
// Program-counter fetch sequencer: offers the PC over valid/ready,
// steps by STEP on accept and redirects on taken branches.
// Ports: clk, rst (async, high), en, br_taken, br_target,
//   addr_valid, addr_ready, pc, fetch_count, misalign.
// Option: define MISALIGN_TRAP_EN to drop misaligned branch targets
//   and raise the sticky misalign flag.
module pc_fetch_sequencer #(
  parameter int WIDTH      = 32,
  parameter int STEP       = 4,
  parameter int RESET_ADDR = 0,
  parameter int CNT_W      = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             br_taken,
  input  logic [WIDTH-1:0] br_target,
  output logic             addr_valid,
  input  logic             addr_ready,
  output logic [WIDTH-1:0] pc,
  output logic [CNT_W-1:0] fetch_count,
  output logic             misalign
);

  typedef enum logic {
    IDLE,
    FETCH
  } state_t;

  localparam logic [WIDTH-1:0] STEP_W = WIDTH'(STEP);
  localparam logic [WIDTH-1:0] RST_PC = WIDTH'(RESET_ADDR);

  state_t           state_q;
  logic [WIDTH-1:0] pc_q;
  logic [WIDTH-1:0] tgt_q;
  logic [CNT_W-1:0] cnt_q;
  logic             valid_q;
  logic             pend_q;
  logic             mis_q;

  logic             hs;
  logic             bad_tgt;
  logic             br_ok;
  logic [WIDTH-1:0] seq_pc_d;

  assign hs = valid_q & addr_ready;

`ifdef MISALIGN_TRAP_EN
  assign bad_tgt = br_taken &
                   ((br_target & (STEP_W - 1'b1)) != '0);
`else
  assign bad_tgt = 1'b0;
`endif

  assign br_ok = br_taken & ~bad_tgt;

  // A latched branch wins over the sequential step.
  assign seq_pc_d = pend_q ? tgt_q : pc_q + STEP_W;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      pc_q    <= RST_PC;
      tgt_q   <= '0;
      cnt_q   <= '0;
      valid_q <= 1'b0;
      pend_q  <= 1'b0;
      mis_q   <= 1'b0;
    end else begin
      mis_q <= mis_q | bad_tgt;
      unique case (state_q)
        IDLE: begin
          if (br_ok) pc_q <= br_target;
          if (en) begin
            state_q <= FETCH;
            valid_q <= 1'b1;
          end
        end
        FETCH: begin
          if (hs) begin
            cnt_q  <= cnt_q + 1'b1;
            pend_q <= 1'b0;
            // A strobe in the accept cycle discards the step.
            pc_q   <= br_ok ? br_target : seq_pc_d;
            if (!en) begin
              state_q <= IDLE;
              valid_q <= 1'b0;
            end
          end else if (br_ok) begin
            // Hold pc stable; newest target wins.
            pend_q <= 1'b1;
            tgt_q  <= br_target;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign addr_valid  = valid_q;
  assign pc          = pc_q;
  assign fetch_count = cnt_q;
  assign misalign    = mis_q;

endmodule

// File: tb/tb_pc_fetch_sequencer.sv
// Bench for pc_fetch_sequencer: directed scenarios plus
// randomized traffic against a transaction-level model.
module tb_pc_fetch_sequencer;

`ifdef MISALIGN_TRAP_EN
  localparam bit MIS = 1'b1;
`else
  localparam bit MIS = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        en = 1'b0;
  logic        br_taken = 1'b0;
  logic [31:0] br_target = '0;
  logic        addr_valid;
  logic        addr_ready = 1'b0;
  logic [31:0] pc;
  logic [15:0] fetch_count;
  logic        misalign;

  int checks = 0;
  int errors = 0;

  // model state
  logic [31:0] m_pc;
  logic [31:0] m_tgt;
  bit          m_run;
  bit          m_pend;
  bit          m_mis;
  int          m_cnt;

  pc_fetch_sequencer dut (
    .clk        (clk),
    .rst        (rst),
    .en         (en),
    .br_taken   (br_taken),
    .br_target  (br_target),
    .addr_valid (addr_valid),
    .addr_ready (addr_ready),
    .pc         (pc),
    .fetch_count(fetch_count),
    .misalign   (misalign)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    en = 0; br_taken = 0;
    br_target = '0; addr_ready = 0;
    rst = 1;
    tick();
    rst = 0;
  endtask

  task automatic test_reset();
    do_reset();
    checks++;
    if (addr_valid !== 1'b0 || pc !== 32'h0 ||
        fetch_count !== 16'h0 || misalign !== 1'b0) begin
      errors++;
      $display("FAIL reset_idle: v=%b pc=%h cnt=%0d mis=%b want 0/0/0/0",
               addr_valid, pc, fetch_count, misalign);
    end
    en = 1; addr_ready = 1;
    repeat (3) tick();
    #2 rst = 1;
    #1;
    checks++;
    if (addr_valid !== 1'b0 || pc !== 32'h0 ||
        fetch_count !== 16'h0) begin
      errors++;
      $display("FAIL reset_async: v=%b pc=%h cnt=%0d want 0/0/0",
               addr_valid, pc, fetch_count);
    end
    tick();
    rst = 0;
    en = 0; addr_ready = 0;
  endtask

  task automatic test_stream();
    do_reset();
    en = 1; addr_ready = 1;
    for (int i = 0; i < 4; i++) begin
      tick();
      checks++;
      if (addr_valid !== 1'b1 || pc !== 32'(4 * i)) begin
        errors++;
        $display("FAIL stream_%0d: v=%b pc=%h want 1/%h",
                 i, addr_valid, pc, 32'(4 * i));
      end
    end
    tick();
    checks++;
    if (fetch_count !== 16'd4 || pc !== 32'h10) begin
      errors++;
      $display("FAIL stream_cnt: cnt=%0d pc=%h want 4/10",
               fetch_count, pc);
    end
  endtask

  // Streams from reset until pc=0x8 is on the bus, then ready=0.
  task automatic run_to_8();
    do_reset();
    en = 1; addr_ready = 1;
    repeat (3) tick();
    addr_ready = 0;
  endtask

  task automatic test_backpressure();
    run_to_8();
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if (addr_valid !== 1'b1 || pc !== 32'h8) begin
        errors++;
        $display("FAIL bp_hold_%0d: v=%b pc=%h want 1/8",
                 i, addr_valid, pc);
      end
    end
    addr_ready = 1;
    tick();
    checks++;
    if (pc !== 32'hC || fetch_count !== 16'd3) begin
      errors++;
      $display("FAIL bp_release: pc=%h cnt=%0d want C/3",
               pc, fetch_count);
    end
  endtask

  task automatic test_branch();
    run_to_8();
    br_taken = 1; br_target = 32'h100;
    tick();
    br_taken = 0; br_target = 32'h0;
    tick();
    checks++;
    if (pc !== 32'h8 || addr_valid !== 1'b1) begin
      errors++;
      $display("FAIL br_pending: pc=%h v=%b want 8/1",
               pc, addr_valid);
    end
    addr_ready = 1;
    tick();
    checks++;
    if (pc !== 32'h100) begin
      errors++;
      $display("FAIL br_after_hs: pc=%h want 100", pc);
    end
    br_taken = 1; br_target = 32'h200;
    tick();
    br_taken = 0;
    checks++;
    if (pc !== 32'h200) begin
      errors++;
      $display("FAIL br_coincident: pc=%h want 200", pc);
    end
    tick();
    checks++;
    if (pc !== 32'h204) begin
      errors++;
      $display("FAIL br_resume: pc=%h want 204", pc);
    end
  endtask

  task automatic test_wrap_pause();
    do_reset();
    br_taken = 1; br_target = 32'hFFFF_FFFC;
    tick();
    br_taken = 0;
    checks++;
    if (pc !== 32'hFFFF_FFFC || addr_valid !== 1'b0) begin
      errors++;
      $display("FAIL idle_branch: pc=%h v=%b want FFFFFFFC/0",
               pc, addr_valid);
    end
    en = 1;
    tick();
    addr_ready = 1;
    tick();
    checks++;
    if (pc !== 32'h0 || fetch_count !== 16'd1) begin
      errors++;
      $display("FAIL wrap: pc=%h cnt=%0d want 0/1",
               pc, fetch_count);
    end
    addr_ready = 0; en = 0;
    tick();
    checks++;
    if (addr_valid !== 1'b1 || pc !== 32'h0) begin
      errors++;
      $display("FAIL pause_hold: v=%b pc=%h want 1/0",
               addr_valid, pc);
    end
    addr_ready = 1;
    tick();
    tick();
    checks++;
    if (addr_valid !== 1'b0 || pc !== 32'h4 ||
        fetch_count !== 16'd2) begin
      errors++;
      $display("FAIL pause_idle: v=%b pc=%h cnt=%0d want 0/4/2",
               addr_valid, pc, fetch_count);
    end
  endtask

  task automatic test_misalign();
    do_reset();
    en = 1; addr_ready = 1;
    repeat (5) tick();
    br_taken = 1; br_target = 32'h102;
    tick();
    br_taken = 0; br_target = 32'h0;
    checks++;
    if (pc !== (MIS ? 32'h14 : 32'h102) ||
        misalign !== MIS) begin
      errors++;
      $display("FAIL misalign: pc=%h mis=%b want %h/%b", pc,
               misalign, MIS ? 32'h14 : 32'h102, MIS);
    end
    repeat (2) tick();
    checks++;
    if (misalign !== MIS) begin
      errors++;
      $display("FAIL misalign_sticky: mis=%b want %b",
               misalign, MIS);
    end
  endtask

  // Reference: transaction view of the fetch stream.
  task automatic model_edge(input bit e, input bit b,
                            input bit r, input logic [31:0] t);
    bit usable;
    usable = b && !(MIS && (t % 4 != 0));
    if (MIS && b && (t % 4 != 0)) m_mis = 1;
    if (!m_run) begin
      if (usable) m_pc = t;
      m_run = e;
    end else if (r) begin
      m_cnt = (m_cnt + 1) % 65536;
      if (usable) m_pc = t;
      else if (m_pend) m_pc = m_tgt;
      else m_pc = m_pc + 32'd4;
      m_pend = 0;
      m_run = e;
    end else if (usable) begin
      m_pend = 1;
      m_tgt = t;
    end
  endtask

  task automatic test_random();
    bit e, b, r;
    logic [31:0] t;
    do_reset();
    m_pc = 0; m_tgt = 0; m_run = 0;
    m_pend = 0; m_mis = 0; m_cnt = 0;
    for (int i = 0; i < 3000; i++) begin
      e = ($urandom_range(0, 9) != 0);
      r = ($urandom_range(0, 2) != 0);
      b = ($urandom_range(0, 6) == 0);
      t = $urandom();
      if ($urandom_range(0, 7) != 0) t[1:0] = 2'b00;
      if ($urandom_range(0, 9) == 0) t = 32'hFFFF_FFF8;
      en = e; addr_ready = r;
      br_taken = b; br_target = t;
      tick();
      model_edge(e, b, r, t);
      checks++;
      if (pc !== m_pc || addr_valid !== m_run ||
          fetch_count !== 16'(m_cnt) ||
          misalign !== m_mis) begin
        errors++;
        $display("FAIL rand_%0d: pc=%h v=%b cnt=%0d mis=%b want %h/%b/%0d/%b",
                 i, pc, addr_valid, fetch_count, misalign,
                 m_pc, m_run, m_cnt, m_mis);
      end
    end
    br_taken = 0;
  endtask

  initial begin
    test_reset();
    test_stream();
    test_backpressure();
    test_branch();
    test_wrap_pause();
    test_misalign();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
